// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux, fixed-select or round-robin.
// Define STREAM_MUX_CH_ID_EN to add OUT_CH, the source channel of the held word.
module stream_mux_rr #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N*W-1:0]   IN_DATA,
    input  logic [N-1:0]     IN_VALID,
    output logic [N-1:0]     IN_READY,
    input  logic             MODE,
    input  logic [SEL_W-1:0] SEL,
    output logic [W-1:0]     OUT_DATA,
`ifdef STREAM_MUX_CH_ID_EN
    output logic [SEL_W-1:0] OUT_CH,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;

`ifdef STREAM_MUX_CH_ID_EN
    logic [SEL_W-1:0] ch_q, ch_d;
`endif

    assign load_en = (state_q == EMPTY) || OUT_READY;

    // Round-robin search starts just past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (RST_N && load_en) begin
            if (!MODE) begin
                if (int'(SEL) < N) begin
                    if (IN_VALID[SEL]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL;
                    end
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (!grant_vld && IN_VALID[(int'(ptr_q) + k) % N]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'((int'(ptr_q) + k) % N);
                    end
                end
            end
        end
    end

    always_comb begin
        IN_READY = '0;
        if (grant_vld) begin
            IN_READY[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
`ifdef STREAM_MUX_CH_ID_EN
        ch_d    = ch_q;
`endif
        if (grant_vld) begin
            state_d = FULL;
            data_d  = IN_DATA[int'(grant_idx)*W +: W];
`ifdef STREAM_MUX_CH_ID_EN
            ch_d    = grant_idx;
`endif
            if (MODE) begin
                ptr_d = grant_idx;
            end
        end else if (load_en) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ptr_q   <= SEL_W'(N - 1);
`ifdef STREAM_MUX_CH_ID_EN
            ch_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
`ifdef STREAM_MUX_CH_ID_EN
            ch_q    <= ch_d;
`endif
        end
    end

    assign OUT_VALID = (state_q == FULL);
    assign OUT_DATA  = data_q;
`ifdef STREAM_MUX_CH_ID_EN
    assign OUT_CH    = ch_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenarios plus random traffic against
// a queue-free behavioural model of the mux (N=4, W=8).
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef STREAM_MUX_CH_ID_EN
    logic [1:0]   out_ch;
`endif

    int errs   = 0;
    int checks = 0;

    // Model state
    bit   m_valid;
    int   m_data;
    int   m_ptr;
    int   m_ch;

    stream_mux_rr #(.N(N), .W(W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .MODE      (mode),
        .SEL       (sel),
        .OUT_DATA  (out_data),
`ifdef STREAM_MUX_CH_ID_EN
        .OUT_CH    (out_ch),
`endif
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Which channel the rules pick this cycle, or -1.
    function automatic int model_grant(bit r, bit md, int s,
                                       logic [3:0] v, bit ordy);
        int idx;
        if (!r) return -1;
        if (m_valid && !ordy) return -1;
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input bit md, input logic [1:0] s,
                        input logic [3:0] v, input logic [31:0] d,
                        input bit ordy, output int g);
        int exp_rdy;
        @(negedge clk);
        rst_n     = r;
        mode      = md;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        g = model_grant(r, md, int'(s), v, ordy);
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        chk("in_ready", int'(in_ready), exp_rdy);
        @(posedge clk);
        #1;
        if (!r) begin
            m_valid = 0;
            m_data  = 0;
            m_ptr   = N - 1;
            m_ch    = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = int'((d >> (g * W)) & 32'hFF);
            m_ch    = g;
            if (md) m_ptr = g;
        end else if (!m_valid || ordy) begin
            m_valid = 0;
        end
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_data", int'(out_data), m_data);
`ifdef STREAM_MUX_CH_ID_EN
        chk("out_ch", int'(out_ch), m_ch);
`endif
    endtask

    localparam logic [31:0] SEQ = 32'hA3A2A1A0;

    initial begin
        int g;
        logic [31:0] rd;
        logic [7:0]  exp_seq [5];
        exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        m_valid = 0; m_data = 0; m_ptr = N - 1; m_ch = 0;
        rst_n = 0; mode = 1; sel = 0; in_valid = 4'hF;
        in_data = SEQ; out_ready = 1;

        // 1: reset with all valid, then channel 0 first
        step(0, 1, 0, 4'hF, SEQ, 1, g);
        step(0, 1, 0, 4'hF, SEQ, 1, g);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);

        // 2: round robin A0..A3,A0 back to back
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 4'hF, SEQ, 1, g);
            if (i == 0) chk("tp1_first_grant", g, 0);
            chk("tp2_seq", int'(out_data), int'(exp_seq[i]));
            chk("tp2_valid", int'(out_valid), 1);
        end

        // 3: fixed select 2, then unavailable channel 3
        step(1, 0, 2, 4'hF, 32'h115C2233, 1, g);
        chk("tp3_ready", int'(in_ready), 4'b0100);
        chk("tp3_data", int'(out_data), 8'h5C);
        step(1, 0, 3, 4'h7, 32'h115C2233, 1, g);
        chk("tp3_nogrant", int'(out_valid), 0);

        // 4: stall three cycles, then no-bubble resume
        step(1, 0, 1, 4'hF, 32'h00007700, 0, g);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 4'hF, 32'h000000EE, 0, g);
            chk("tp4_hold", int'(out_data), 8'h77);
            chk("tp4_rdy0", int'(in_ready), 0);
        end
        step(1, 0, 0, 4'hF, 32'h000000EE, 1, g);
        chk("tp4_resume", int'(out_data), 8'hEE);

        // 5: pointer at 1, channels 0 and 3 valid -> 3 then 0
        step(1, 1, 0, 4'h2, 32'h00001100, 1, g);
        step(1, 1, 0, 4'h9, 32'hD30000D0, 1, g);
        chk("tp5_first", g, 3);
        step(1, 1, 0, 4'h9, 32'hD30000D0, 1, g);
        chk("tp5_wrap", g, 0);

        // 6: reset pulse while full and stalled
        step(1, 1, 0, 4'h4, 32'h00420000, 1, g);
        step(1, 1, 0, 4'hF, SEQ, 0, g);
        step(0, 1, 0, 4'hF, SEQ, 0, g);
        chk("tp6_valid", int'(out_valid), 0);
        step(1, 1, 0, 4'hF, SEQ, 1, g);
        chk("tp6_restart", g, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            step(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom),
                 4'($urandom), rd, ($urandom_range(0, 3) != 0), g);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
